// File: rtl/uart_rx.sv
// 8N1 UART receiver, 8x oversampled, with glitch-start rejection and framing errors.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting around each sample point.
module uart_rx #(
    parameter int TICK_DIV   = 43,
    parameter int OVERSAMPLE = 8,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic       user_clock,
    input  logic       rst,
    input  logic       usb_rs232_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_frame_err,
    output logic       rx_busy
);

    localparam int DW = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_MAX = DW'(TICK_DIV - 1);
    localparam logic [2:0] LAST_PH = 3'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [2:0] START_PH = 3'd4;
`else
    localparam logic [2:0] START_PH = 3'd3;
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t     state, state_n;
    logic       sync1, rxd_s;
    logic [DW-1:0] div;
    logic       tick;
    logic       samp;
    logic [2:0] phase, phase_n;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shreg, shreg_n;
    logic [7:0] data_n;
    logic       valid_n, err_n;

    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= usb_rs232_rxd;
            rxd_s <= sync1;
        end
    end

    assign tick = (div == DIV_MAX);

    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst)      div <= '0;
        else if (tick) div <= '0;
        else           div <= div + 1'b1;
    end

`ifdef UART_RX_MAJORITY_EN
    // hist holds rxd_s from the two previous ticks; vote with the current one
    logic [1:0] hist;

    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst)      hist <= 2'b11;
        else if (tick) hist <= {hist[0], rxd_s};
    end

    assign samp = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
    assign samp = rxd_s;
`endif

    always_ff @(posedge user_clock or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            phase        <= '0;
            bit_idx      <= '0;
            shreg        <= '0;
            rx_data      <= 8'h00;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_n;
            phase        <= phase_n;
            bit_idx      <= bit_n;
            shreg        <= shreg_n;
            rx_data      <= data_n;
            rx_valid     <= valid_n;
            rx_frame_err <= err_n;
        end
    end

    always_comb begin
        state_n = state;
        phase_n = phase;
        bit_n   = bit_idx;
        shreg_n = shreg;
        data_n  = rx_data;
        valid_n = 1'b0;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick && !rxd_s) begin
                    state_n = START;
                    phase_n = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (phase == START_PH) begin
                        if (samp) begin
                            state_n = IDLE;
                        end else begin
                            state_n = DATA;
                            phase_n = '0;
                            bit_n   = '0;
                        end
                    end else begin
                        phase_n = phase + 3'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    phase_n = phase + 3'd1;
                    if (phase == LAST_PH) begin
                        if (MSB_FIRST) shreg_n = {shreg[6:0], samp};
                        else           shreg_n = {samp, shreg[7:1]};
                        bit_n = bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state_n = STOP;
                            phase_n = '0;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (phase == LAST_PH) begin
                        if (samp) begin
                            data_n  = shreg;
                            valid_n = 1'b1;
                            state_n = IDLE;
                        end else begin
                            err_n   = 1'b1;
                            state_n = BRK;
                        end
                    end else begin
                        phase_n = phase + 3'd1;
                    end
                end
            end
            BRK: begin
                // one error per break: wait for the line to return high
                if (rxd_s) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign rx_busy = (state != IDLE);

endmodule
